// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: state encoding, opcodes, reset vector
// and the branch-offset helper used by the next-pc selector.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  // Sign-extended word offset of a 16-bit branch immediate.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational redirect target computation with jr > jmp > branch > sequential priority.
module next_pc_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [25:0]     target_i,
  input  logic [29:0]     rs_word_i,
  input  logic            jr_i,
  input  logic            jmp_i,
  input  logic            pc_src_i,
  output logic [XLEN-1:0] next_pc_o
);

  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] jmp_target;
  logic [XLEN-1:0] br_target;

  // The immediate lives in target_i[15:0]; the branch sum wraps naturally at 32 bits.
  assign jr_target  = {rs_word_i, 2'b00};
  assign jmp_target = {pc_plus4_i[31:28], target_i, 2'b00};
  assign br_target  = pc_plus4_i + branch_offset(target_i[15:0]);

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jr_i) begin
      next_pc_o = jr_target;
    end else if (jmp_i) begin
      next_pc_o = jmp_target;
    end else if (pc_src_i) begin
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: requests the word at pc, holds it for the controller,
// then redirects pc on acknowledge.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        pc_src,
  input  logic        jmp,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            misalign_q, misalign_d;
  logic            imem_req_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4 = pc_q + XLEN'(4);

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i (pc_plus4),
    .target_i   (inst_q[25:0]),
    .rs_word_i  (rs_data[31:2]),
    .jr_i       (jr),
    .jmp_i      (jmp),
    .pc_src_i   (pc_src),
    .next_pc_o  (next_pc)
  );

  // State and datapath registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      count_q      <= '0;
      misalign_q   <= 1'b0;
      imem_req_q   <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      count_q      <= count_d;
      misalign_q   <= misalign_d;
      imem_req_q   <= (state_d == S_FETCH);
      inst_valid_q <= (state_d == S_HOLD);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ack) begin
          pc_d    = next_pc;
          count_d = count_q + XLEN'(1);
          state_d = S_FETCH;
          if (jr && (rs_data[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = inst_valid_q;
  assign pc           = pc_q;
  assign fetch_count  = count_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance covers the RESET_PC override.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_ack, pc_src, jmp, jr;
  logic [31:0] rs_data;

  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst, pc, pc_plus4, fetch_count;
  logic        d2_imem_req, d2_inst_valid, d2_misalign_err;
  logic [31:0] d2_imem_addr, d2_inst, d2_pc, d2_pc_plus4, d2_fetch_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .inst_ack(inst_ack), .pc_src(pc_src), .jmp(jmp),
    .jr(jr), .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  instr_fetch_unit #(.RESET_PC(32'h8000_0000)) u_dut2 (
    .clk(clk), .rst(rst), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(d2_inst),
    .inst_valid(d2_inst_valid), .inst_ack(inst_ack), .pc_src(pc_src), .jmp(jmp),
    .jr(jr), .rs_data(rs_data), .pc(d2_pc), .pc_plus4(d2_pc_plus4),
    .fetch_count(d2_fetch_count), .misalign_err(d2_misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    step();
    imem_ready = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_ack(input logic a_jr, input logic a_jmp, input logic a_src,
                        input logic [31:0] rs);
    inst_ack = 1'b1;
    jr       = a_jr;
    jmp      = a_jmp;
    pc_src   = a_src;
    rs_data  = rs;
    step();
    inst_ack = 1'b0;
    jr       = 1'b0;
    jmp      = 1'b0;
    pc_src   = 1'b0;
    rs_data  = '0;
    exp_count = exp_count + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b0; imem_rdata = '0; inst_ack = 1'b0;
    pc_src = 1'b0; jmp = 1'b0; jr = 1'b0; rs_data = '0;
    step(); step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b want 1", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    checks++; if (d2_imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr2 got %h want 80000000", d2_imem_addr); end
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_basic();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr0 got %h want 0", imem_addr); end
    do_fetch(32'h1234_5678);
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_hold got %b want 0", imem_req); end
    checks++; if (inst !== 32'h1234_5678) begin errors++; $display("FAIL basic_inst got %h want 12345678", inst); end
    do_ack(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_addr4 got %h want 4", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req_fetch got %b want 1", imem_req); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL basic_count got %0d want 1", fetch_count); end
  endtask

  task automatic test_branch();
    do_fetch({OP_J, 26'h10});
    do_ack(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL j_to_40 got %h want 40", imem_addr); end
    do_fetch({OP_BEQ, 5'd1, 5'd2, 16'hFFFF});
    checks++; if (pc_plus4 !== 32'h44) begin errors++; $display("FAIL beq_pc_plus4 got %h want 44", pc_plus4); end
    do_ack(1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL beq_back got %h want 40", imem_addr); end
    checks++; if (fetch_count !== exp_count) begin errors++; $display("FAIL beq_count got %0d want %0d", fetch_count, exp_count); end
  endtask

  task automatic test_jump_priority();
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h1000_0010);
    do_fetch({OP_J, 26'h0000100});
    do_ack(1'b1, 1'b1, 1'b0, 32'h200);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jr_wins got %h want 200", imem_addr); end
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h1000_0010);
    do_fetch({OP_J, 26'h0000100});
    do_ack(1'b0, 1'b1, 1'b1, 32'h200);
    checks++; if (imem_addr !== 32'h1000_0400) begin errors++; $display("FAIL jmp_region got %h want 10000400", imem_addr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL jmp_no_misalign got %b want 0", misalign_err); end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = 32'h1000_0400;
    inst_ack = 1'b1; pc_src = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== p) begin
        errors++; $display("FAIL stall_fetch%0d got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, p);
      end
    end
    inst_ack = 1'b0; pc_src = 1'b0;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("FAIL stall_ack_ignored got %0d want %0d", fetch_count, exp_count); end
    do_fetch(32'hCAFE_0001);
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (inst !== 32'hCAFE_0001 || pc !== p || fetch_count !== exp_count || inst_valid !== 1'b1) begin
        errors++; $display("FAIL hold%0d got inst=%h pc=%h cnt=%0d v=%b want %h %h %0d 1", i, inst, pc, fetch_count, inst_valid, 32'hCAFE_0001, p, exp_count);
      end
    end
    imem_ready = 1'b0; imem_rdata = '0;
    do_ack(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h1000_0404) begin errors++; $display("FAIL stall_resume got %h want 10000404", imem_addr); end
  endtask

  task automatic test_misalign();
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h203);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL misalign_addr got %h want 200", imem_addr); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set got %b want 1", misalign_err); end
    do_fetch(32'h0);
    do_ack(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign_err); end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h want 0", pc_plus4); end
    do_fetch({OP_BEQ, 10'd0, 16'h0001});
    do_ack(1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_branch got %h want 4", imem_addr); end
    checks++; if (fetch_count !== exp_count) begin errors++; $display("FAIL wrap_count got %0d want %0d", fetch_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h80);
    do_fetch(32'hDEAD_BEEF);
    checks++; if (d2_pc !== 32'h80 || pc !== 32'h80) begin errors++; $display("FAIL pre_rst_pc got %h/%h want 80", pc, d2_pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h0 || inst !== 32'h0) begin
      errors++; $display("FAIL async_rst got v=%b req=%b pc=%h inst=%h want 0 1 0 0", inst_valid, imem_req, pc, inst);
    end
    checks++; if (fetch_count !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL async_rst_cnt got %0d/%b want 0/0", fetch_count, misalign_err); end
    checks++; if (d2_pc !== 32'h8000_0000) begin errors++; $display("FAIL async_rst_pc2 got %h want 80000000", d2_pc); end
    step();
    rst = 1'b0;
    exp_count = 0;
    step();
    checks++; if (d2_imem_addr !== 32'h8000_0000 || d2_imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_addr2 got %h req=%b want 80000000 1", d2_imem_addr, d2_imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr got %h want 0", imem_addr); end
    do_fetch(32'h0);
    do_ack(1'b1, 1'b0, 1'b0, 32'h80);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h0 || inst_valid !== 1'b0 || fetch_count !== 32'h0) begin
      errors++; $display("FAIL rst_mid_fetch got addr=%h v=%b cnt=%0d want 0 0 0", imem_addr, inst_valid, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_jump_priority();
    test_stall();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
